rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (rd_waddr/rd_wen/rd_wdata) between two
//   writeback requesters: req0 = ALU result path, req1 = load/long-latency path.
//   Fixed priority to req0, with a starvation counter that forces a req1 grant.
//   Registered output stage drives the rf write port directly.
// PARAMETERS
//   DATA_W        32  write data width
//   ADDR_W         5  register address width
//   STARVE_LIMIT   4  consecutive denied req1 cycles before a forced req1 grant (>=1)
// PORTS
//   i_clk          in   1       clock, rising edge
//   i_rst_n        in   1       asynchronous reset, active-low
//   i_hold         in   1       1 = grant nothing this cycle (pipeline stall)
//   i_req0_valid   in   1       req0 has a write pending
//   i_req0_addr    in   ADDR_W  req0 destination register
//   i_req0_data    in   DATA_W  req0 write data
//   o_req0_ready   out  1       req0 accepted this cycle (combinational)
//   i_req1_valid   in   1       req1 has a write pending
//   i_req1_addr    in   ADDR_W  req1 destination register
//   i_req1_data    in   DATA_W  req1 write data
//   o_req1_ready   out  1       req1 accepted this cycle (combinational)
//   o_rd_wen       out  1       rf write enable (registered)
//   o_rd_waddr     out  ADDR_W  rf write address (registered)
//   o_rd_wdata     out  DATA_W  rf write data (registered)
//   o_grant0_cnt   out  16      req0 accepts (stats, see CONFIGURATION)
//   o_grant1_cnt   out  16      req1 accepts (stats)
//   o_conflict_cnt out  16      cycles with both valid and !i_hold (stats)
// BEHAVIOUR
//   - Reset (i_rst_n=0, async): o_rd_wen/o_rd_waddr/o_rd_wdata=0, starve cnt=0, stats=0.
//     Any write in the output stage is discarded; no rf write occurs during reset.
//   - Handshake: transfer when valid&&ready. Requester holds valid/addr/data stable
//     until ready. Ready never asserts without valid; at most one ready per cycle.
//   - Grant decision (combinational, each cycle):
//       i_hold=1                               -> no grant
//       else req1_valid && starve==STARVE_LIMIT -> grant req1
//       else req0_valid                         -> grant req0
//       else req1_valid                         -> grant req1
//   - Starve counter, width $clog2(STARVE_LIMIT+1): i_hold=1 -> holds;
//     req1 granted or req1_valid=0 -> 0; req1 valid and denied -> +1, saturates.
//   - Output stage, latency 1 cycle: on grant, next edge loads waddr/wdata from the
//     winner; o_rd_wen=1 unless addr==0 (x0 write accepted but dropped, wen=0).
//     No grant -> o_rd_wen=0; waddr/wdata hold their last value.
//   - Back-to-back grants every cycle allowed; no internal queue, no bubbles.
//   - STARVE_LIMIT=1 with both valid continuously -> strict alternation 0,1,0,1...
// CONFIGURATION
//   RF_WB_STATS_EN defined: three 16-bit counters, wrap on overflow, cleared on reset;
//     grant counters +1 per accepted transfer (x0 writes included); conflict +1 per
//     cycle with both valid and i_hold=0.
//   Not defined: counters not built, the three ports are tied to 16'h0.
// TESTING
//   1. Assert i_rst_n=0 mid-write -> o_rd_wen=0, addr/data=0 immediately (async).
//   2. req0 valid addr=5 data=32'hDEADBEEF -> o_req0_ready=1 same cycle;
//      next cycle o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=32'hDEADBEEF.
//   3. Both valid continuously, STARVE_LIMIT=4 -> ready0 for 4 cycles, ready1 on
//      5th, repeating; o_rd_waddr sequence follows grants one cycle later.
//   4. req1 valid addr=0 data=32'h1234 alone -> o_req1_ready=1, o_rd_wen stays 0.
//   5. Both valid, starve=3, i_hold=1 for 3 cycles -> no ready, cnt stays 3;
//      i_hold=0 -> one more req0 grant, then req1 granted.
//   6. RF_WB_STATS_EN, run 3 for 10 cycles -> grant0=8, grant1=2, conflict=10;
//      without macro all three read 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Writeback handshake and register-file write port bundle.
// master = requesters/rf side, slave = arbiter side.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              i_hold;
    logic              i_req0_valid;
    logic [ADDR_W-1:0] i_req0_addr;
    logic [DATA_W-1:0] i_req0_data;
    logic              o_req0_ready;
    logic              i_req1_valid;
    logic [ADDR_W-1:0] i_req1_addr;
    logic [DATA_W-1:0] i_req1_data;
    logic              o_req1_ready;
    logic              o_rd_wen;
    logic [ADDR_W-1:0] o_rd_waddr;
    logic [DATA_W-1:0] o_rd_wdata;

    modport master (
        output i_hold,
        output i_req0_valid, i_req0_addr, i_req0_data,
        input  o_req0_ready,
        output i_req1_valid, i_req1_addr, i_req1_data,
        input  o_req1_ready,
        input  o_rd_wen, o_rd_waddr, o_rd_wdata
    );

    modport slave (
        input  i_hold,
        input  i_req0_valid, i_req0_addr, i_req0_data,
        output o_req0_ready,
        input  i_req1_valid, i_req1_addr, i_req1_data,
        output o_req1_ready,
        output o_rd_wen, o_rd_waddr, o_rd_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: fixed priority to req0 with a
// starvation override for req1. Optional stats via RF_WB_STATS_EN.
module rf_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    rf_wb_arbiter_if.slave bus,
    output logic [15:0] o_grant0_cnt,
    output logic [15:0] o_grant1_cnt,
    output logic [15:0] o_conflict_cnt
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0]     starve_q, starve_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt0, gnt1;
    logic              v0, v1;

    assign v0 = bus.i_req0_valid;
    assign v1 = bus.i_req1_valid;

    // Grant decision: stall, then starvation override, then fixed priority
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        priority case (1'b1)
            bus.i_hold:              ;
            (v1 && starve_q == LIM): gnt1 = 1'b1;
            v0:                      gnt0 = 1'b1;
            v1:                      gnt1 = 1'b1;
            default:                 ;
        endcase
    end

    assign bus.o_req0_ready = gnt0;
    assign bus.o_req1_ready = gnt1;

    // Next-state for starvation counter and output stage
    always_comb begin
        starve_d = starve_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (!bus.i_hold) begin
            if (gnt1 || !v1)
                starve_d = '0;
            else if (starve_q != LIM)
                starve_d = starve_q + 1'b1;
        end
        if (gnt0) begin
            waddr_d = bus.i_req0_addr;
            wdata_d = bus.i_req0_data;
            wen_d   = (bus.i_req0_addr != '0);
        end else if (gnt1) begin
            waddr_d = bus.i_req1_addr;
            wdata_d = bus.i_req1_data;
            wen_d   = (bus.i_req1_addr != '0);
        end
    end

    // Registered write port and starvation state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.o_rd_wen   = wen_q;
    assign bus.o_rd_waddr = waddr_q;
    assign bus.o_rd_wdata = wdata_q;

`ifdef RF_WB_STATS_EN
    logic [15:0] g0_q, g1_q, cf_q;

    // Wrapping accept and conflict counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            g0_q <= '0;
            g1_q <= '0;
            cf_q <= '0;
        end else begin
            if (gnt0)
                g0_q <= g0_q + 16'd1;
            if (gnt1)
                g1_q <= g1_q + 16'd1;
            if (v0 && v1 && !bus.i_hold)
                cf_q <= cf_q + 16'd1;
        end
    end

    assign o_grant0_cnt   = g0_q;
    assign o_grant1_cnt   = g1_q;
    assign o_conflict_cnt = cf_q;
`else
    assign o_grant0_cnt   = 16'h0;
    assign o_grant1_cnt   = 16'h0;
    assign o_conflict_cnt = 16'h0;
`endif
endmodule
